// File: rtl/braille_stream_codec.sv
// rtl/braille_stream_codec.sv - character-serial bidirectional Braille codec with output FIFO
module braille_stream_codec #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [5:0] CELL_CAP    = 6'b000001;
  localparam logic [5:0] CELL_NUM    = 6'b001111;
  localparam logic [5:0] CELL_LET    = 6'b000011;
  localparam logic [5:0] CELL_SPACE  = 6'b000000;
  localparam logic [5:0] CELL_PERIOD = 6'b010011;
  localparam logic [5:0] CELL_COMMA  = 6'b010000;

  typedef enum logic [1:0] {IDLE, EMIT_PRE, EMIT_MAIN} state_t;

  state_t state, state_nxt;

  // Letter cells a..z; digits 1..9,0 reuse indices 0..9
  function automatic logic [5:0] letter_cell(input logic [7:0] idx);
    case (idx)
      8'd0:    letter_cell = 6'b100000;
      8'd1:    letter_cell = 6'b110000;
      8'd2:    letter_cell = 6'b100100;
      8'd3:    letter_cell = 6'b100110;
      8'd4:    letter_cell = 6'b100010;
      8'd5:    letter_cell = 6'b110100;
      8'd6:    letter_cell = 6'b110110;
      8'd7:    letter_cell = 6'b110010;
      8'd8:    letter_cell = 6'b010100;
      8'd9:    letter_cell = 6'b010110;
      8'd10:   letter_cell = 6'b101000;
      8'd11:   letter_cell = 6'b111000;
      8'd12:   letter_cell = 6'b101100;
      8'd13:   letter_cell = 6'b101110;
      8'd14:   letter_cell = 6'b101010;
      8'd15:   letter_cell = 6'b111100;
      8'd16:   letter_cell = 6'b111110;
      8'd17:   letter_cell = 6'b111010;
      8'd18:   letter_cell = 6'b011100;
      8'd19:   letter_cell = 6'b011110;
      8'd20:   letter_cell = 6'b101001;
      8'd21:   letter_cell = 6'b111001;
      8'd22:   letter_cell = 6'b010111;
      8'd23:   letter_cell = 6'b101101;
      8'd24:   letter_cell = 6'b101111;
      8'd25:   letter_cell = 6'b101011;
      default: letter_cell = 6'b000000;
    endcase
  endfunction

  logic             num_run, cap_pend, last_mode;
  logic             ctx_num, ctx_cap;
  logic [7:0]       idx;
  logic             lhit;
  logic [7:0]       lidx;
  logic             d_pre, d_out, d_err, d_num, d_cap;
  logic [5:0]       d_pre_cell;
  logic [7:0]       d_main;
  logic [5:0]       pre_cell;
  logic [7:0]       main_data;
  logic             main_err;
  logic             full, empty, core_ready, accept, push, pop;
  logic [8:0]       push_entry;
  logic [8:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  // Reverse lookup of the incoming cell in the letter table
  always_comb begin
    lhit = 1'b0;
    lidx = 8'd0;
    for (int i = 0; i < 26; i++) begin
      if (letter_cell(8'(i)) == in_data[5:0]) begin
        lhit = 1'b1;
        lidx = 8'(i);
      end
    end
  end

  // Translate one symbol: optional prefix, optional main entry, next context
  always_comb begin
    ctx_num    = (mode == last_mode) && num_run;
    ctx_cap    = (mode == last_mode) && cap_pend;
    d_pre      = 1'b0;
    d_pre_cell = 6'b000000;
    d_out      = 1'b0;
    d_main     = 8'h00;
    d_err      = 1'b0;
    d_num      = ctx_num;
    d_cap      = ctx_cap;
    idx        = 8'd0;
    if (!mode) begin
      d_out = 1'b1;
      d_num = 1'b0;
      if (in_data >= 8'h61 && in_data <= 8'h7a) begin
        idx    = in_data - 8'h61;
        d_main = {2'b00, letter_cell(idx)};
        if (ctx_num && idx < 8'd10) begin
          d_pre      = 1'b1;
          d_pre_cell = CELL_LET;
        end
      end else if (in_data >= 8'h41 && in_data <= 8'h5a) begin
        idx        = in_data - 8'h41;
        d_main     = {2'b00, letter_cell(idx)};
        d_pre      = 1'b1;
        d_pre_cell = CELL_CAP;
      end else if (in_data >= 8'h30 && in_data <= 8'h39) begin
        idx    = (in_data == 8'h30) ? 8'd9 : in_data - 8'h31;
        d_main = {2'b00, letter_cell(idx)};
        d_num  = 1'b1;
        if (!ctx_num) begin
          d_pre      = 1'b1;
          d_pre_cell = CELL_NUM;
        end
      end else if (in_data == 8'h20) begin
        d_main = {2'b00, CELL_SPACE};
      end else if (in_data == 8'h2e) begin
        d_main = {2'b00, CELL_PERIOD};
      end else if (in_data == 8'h2c) begin
        d_main = {2'b00, CELL_COMMA};
      end else begin
        d_main = 8'h00;
        d_err  = 1'b1;
      end
    end else begin
      d_cap = 1'b0;
      case (in_data[5:0])
        CELL_CAP:    d_cap = 1'b1;
        CELL_NUM:    d_num = 1'b1;
        CELL_LET:    d_num = 1'b0;
        CELL_SPACE: begin
          d_out  = 1'b1;
          d_main = 8'h20;
          d_num  = 1'b0;
        end
        CELL_PERIOD: begin
          d_out  = 1'b1;
          d_main = 8'h2e;
        end
        CELL_COMMA: begin
          d_out  = 1'b1;
          d_main = 8'h2c;
        end
        default: begin
          d_out = 1'b1;
          if (lhit) begin
            if (ctx_num && lidx < 8'd10)
              d_main = (lidx == 8'd9) ? 8'h30 : 8'h31 + lidx;
            else
              d_main = (ctx_cap ? 8'h41 : 8'h61) + lidx;
          end else begin
            d_main = 8'h3f;
            d_err  = 1'b1;
            d_num  = 1'b0;
          end
        end
      endcase
    end
  end

  assign core_ready = (state == IDLE) || ((state == EMIT_MAIN) && !full);
  assign in_ready   = rst_n && core_ready;
  assign accept     = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and FIFO push selection; an EMIT state holds while the FIFO is full
  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    push_entry = {3'b000, pre_cell};
    case (state)
      IDLE: begin
        if (accept) state_nxt = d_pre ? EMIT_PRE : (d_out ? EMIT_MAIN : IDLE);
      end
      EMIT_PRE: begin
        if (!full) begin
          push      = 1'b1;
          state_nxt = EMIT_MAIN;
        end
      end
      EMIT_MAIN: begin
        if (!full) begin
          push       = 1'b1;
          push_entry = {main_err, main_data};
          if (accept) state_nxt = d_pre ? EMIT_PRE : (d_out ? EMIT_MAIN : IDLE);
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the translated symbol and the updated context on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cell  <= 6'b000000;
      main_data <= 8'h00;
      main_err  <= 1'b0;
      num_run   <= 1'b0;
      cap_pend  <= 1'b0;
      last_mode <= 1'b0;
    end else if (accept) begin
      pre_cell  <= d_pre_cell;
      main_data <= d_main;
      main_err  <= d_err;
      num_run   <= d_num;
      cap_pend  <= d_cap;
      last_mode <= mode;
    end
  end

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && out_ready;

  // FIFO storage; validity is tracked by count so storage needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of errored entries pushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 err_cnt <= '0;
    else if (push && push_entry[8] && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
  end

  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign out_err   = out_valid && mem[rd_ptr][8];
  assign busy      = (state != IDLE) || !empty;

endmodule
